// File: rtl/ts_reader.sv
// ts_reader: periodic serial reader for two temperature sensors sharing sclk/cs_n
// Ports: clk, rst (sync, active high), en (1 = run periodic conversions),
//        sdo1/sdo2 (serial data from each sensor), sclk (idle low), cs_n (active low),
//        ts1/ts2 (last good readings), valid (one-cycle end-of-conversion pulse),
//        err (1 = last conversion rejected because a reading was all-ones)
module ts_reader #(
    parameter int NBITS   = 8,
    parameter int CLK_DIV = 4,
    parameter int PERIOD  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sdo1,
    input  logic             sdo2,
    output logic             sclk,
    output logic             cs_n,
    output logic [NBITS-1:0] ts1,
    output logic [NBITS-1:0] ts2,
    output logic             valid,
    output logic             err
);
    localparam int PW = $clog2(PERIOD + 1);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, UPDATE} state_t;

    state_t           state;
    logic [PW-1:0]    pcnt;
    logic [DW-1:0]    div;
    logic [BW-1:0]    bcnt;
    logic [NBITS-1:0] sr1;
    logic [NBITS-1:0] sr2;
    logic             div_end;
    logic             bad;

    assign div_end = div == DW'(CLK_DIV - 1);
    assign bad     = (&sr1) | (&sr2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
            div   <= '0;
            bcnt  <= '0;
            sr1   <= '0;
            sr2   <= '0;
            sclk  <= 1'b0;
            cs_n  <= 1'b1;
            ts1   <= '0;
            ts2   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!en) begin
                        pcnt <= '0;
                    end else if (pcnt == PW'(PERIOD - 1)) begin
                        pcnt  <= '0;
                        state <= SETUP;
                        cs_n  <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div   <= '0;
                        state <= SHIFT;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div <= div + 1'b1;
                    end else begin
                        div  <= '0;
                        sclk <= ~sclk;
                        // data is captured on the same edge that raises sclk
                        if (!sclk) begin
                            sr1 <= {sr1[NBITS-2:0], sdo1};
                            sr2 <= {sr2[NBITS-2:0], sdo2};
                        end else if (bcnt == BW'(NBITS - 1)) begin
                            bcnt  <= '0;
                            state <= HOLD;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        div   <= '0;
                        state <= UPDATE;
                        cs_n  <= 1'b1;
                        valid <= 1'b1;
                        err   <= bad;
                        // an open line on either sensor keeps both old readings
                        if (!bad) begin
                            ts1 <= sr1;
                            ts2 <= sr2;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                UPDATE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ts_reader.sv
// tb_ts_reader: randomized and directed checks of ts_reader against a timeline model
module tb_ts_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst, en;
    logic [2:0][7:0] v1, v2;
    logic [2:0]      sclk_a, cs_n_a, valid_a, err_a;
    logic [2:0][7:0] ts1_a, ts2_a;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rnd_val();
        return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    endfunction

    // Instance 0: defaults; 1: CLK_DIV=1, PERIOD=5; 2: CLK_DIV=4, PERIOD=1
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CD  = (g == 1) ? 1 : 4;
        localparam int PER = (g == 0) ? 1000 : (g == 1) ? 5 : 1;
        localparam int L   = CD * 18;
        logic sdo1, sdo2, sclk, cs_n, valid, err;
        logic [7:0] ts1, ts2;

        ts_reader #(.NBITS(8), .CLK_DIV(CD), .PERIOD(PER)) dut (
            .clk(clk), .rst(rst[g]), .en(en[g]), .sdo1(sdo1), .sdo2(sdo2),
            .sclk(sclk), .cs_n(cs_n), .ts1(ts1), .ts2(ts2), .valid(valid), .err(err)
        );

        assign sclk_a[g]  = sclk;
        assign cs_n_a[g]  = cs_n;
        assign valid_a[g] = valid;
        assign err_a[g]   = err;
        assign ts1_a[g]   = ts1;
        assign ts2_a[g]   = ts2;

        // Sensor: presents bit (7 - rises seen since cs_n fell), MSB first
        int idx = 0;
        bit ps = 1'b0;
        always @(negedge clk) begin
            if (cs_n !== 1'b0) idx = 0;
            else if (sclk === 1'b1 && !ps) idx++;
            ps = (sclk === 1'b1);
            sdo1 = (idx < 8) ? v1[g][7 - idx] : 1'b0;
            sdo2 = (idx < 8) ? v2[g][7 - idx] : 1'b0;
        end

        // Model: m_t counts edges since a conversion started; outputs follow from it
        int m_idle = 0, m_t = 0;
        bit m_busy = 1'b0, m_upd = 1'b0, m_on = 1'b0, e_valid = 1'b0, e_err = 1'b0;
        logic [7:0] m_b1 = '0, m_b2 = '0, e_ts1 = '0, e_ts2 = '0;
        always @(posedge clk) begin
            if (rst[g]) begin
                m_on = 1'b1; m_busy = 1'b0; m_upd = 1'b0; m_idle = 0; m_t = 0;
                e_valid = 1'b0; e_err = 1'b0; e_ts1 = '0; e_ts2 = '0;
            end else begin
                e_valid = 1'b0;
                if (m_upd) begin
                    m_upd = 1'b0;
                end else if (!m_busy) begin
                    if (en[g]) begin
                        m_idle++;
                        if (m_idle == PER) begin
                            m_busy = 1'b1; m_t = 0; m_idle = 0;
                        end
                    end else begin
                        m_idle = 0;
                    end
                end else begin
                    m_t++;
                    if (m_t >= 2 * CD && m_t <= 16 * CD && m_t % (2 * CD) == 0) begin
                        m_b1 = {m_b1[6:0], sdo1};
                        m_b2 = {m_b2[6:0], sdo2};
                    end
                    if (m_t == L) begin
                        m_busy = 1'b0; m_upd = 1'b1; e_valid = 1'b1;
                        e_err = (m_b1 == 8'hFF) || (m_b2 == 8'hFF);
                        if (!e_err) begin
                            e_ts1 = m_b1; e_ts2 = m_b2;
                        end
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (m_on)
                chk($sformatf("outputs_dut%0d", g), {cs_n, sclk, valid, err, ts1, ts2},
                    {!m_busy, m_busy && m_t >= 2 * CD && m_t < 17 * CD && (m_t / CD) % 2 == 0,
                     e_valid, e_err, e_ts1, e_ts2});
        end
    end

    task automatic timeout_fail(input string name, input int budget);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within %0d cycles", name, budget);
    endtask

    task automatic wait_valid(input int i, input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget && n < 0; c++) begin
            @(negedge clk);
            if (valid_a[i]) n = c;
        end
        if (n < 0) timeout_fail($sformatf("valid_wait%0d", i), budget);
    endtask

    task automatic wait_cs_low(input int i, input int budget);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (cs_n_a[i] && c < budget);
        if (cs_n_a[i]) timeout_fail($sformatf("cs_low_wait%0d", i), budget);
    endtask

    task automatic wait_rises(input int i, input int k, input int budget);
        int seen = 0;
        logic p = 1'b0;
        for (int c = 0; c < budget && seen < k; c++) begin
            @(negedge clk);
            if (sclk_a[i] && !p) seen++;
            p = sclk_a[i];
        end
        if (seen < k) timeout_fail($sformatf("sclk_rise_wait%0d", i), budget);
    endtask

    function automatic logic [19:0] outs(input int i);
        return {cs_n_a[i], sclk_a[i], valid_a[i], err_a[i], ts1_a[i], ts2_a[i]};
    endfunction

    initial begin
        rst = 3'b111;
        en  = 3'b000;
        v1  = '0;
        v2  = '0;
        fork
            fork
                begin : s0
                    int n;
                    v1[0] = 8'h3C; v2[0] = 8'h28;
                    @(negedge clk);
                    chk("reset0", outs(0), 20'h80000);
                    @(negedge clk);
                    rst[0] = 1'b0; en[0] = 1'b1;
                    wait_valid(0, 1200, n);
                    chk("t1_latency", n, 1072);
                    chk("t1_ts1", ts1_a[0], 8'h3C);
                    chk("t1_ts2", ts2_a[0], 8'h28);
                    chk("t1_err", err_a[0], 1'b0);
                    v1[0] = 8'hFF; v2[0] = 8'h50;
                    wait_valid(0, 1200, n);
                    chk("t2_spacing", n, 1073);
                    chk("t2_err", err_a[0], 1'b1);
                    chk("t2_ts1", ts1_a[0], 8'h3C);
                    chk("t2_ts2", ts2_a[0], 8'h28);
                    repeat (3) begin
                        v1[0] = rnd_val(); v2[0] = rnd_val();
                        en[0] = 1'b0;
                        repeat ($urandom_range(0, 20)) @(negedge clk);
                        en[0] = 1'b1;
                        wait_valid(0, 1200, n);
                    end
                end
                begin : s1
                    int n, cnt, k, c;
                    @(negedge clk);
                    chk("reset1", outs(1), 20'h80000);
                    @(negedge clk);
                    rst[1] = 1'b0; en[1] = 1'b1; v1[1] = 8'h00; v2[1] = 8'h7F;
                    wait_cs_low(1, 50);
                    wait_valid(1, 50, n);
                    chk("t5_latency", n, 18);
                    chk("t5_ts1", ts1_a[1], 8'h00);
                    chk("t5_ts2", ts2_a[1], 8'h7F);
                    chk("t5_err", err_a[1], 1'b0);
                    v1[1] = 8'h5A; v2[1] = 8'hA5;
                    wait_cs_low(1, 50);
                    wait_rises(1, 3, 50);
                    @(negedge clk);
                    en[1] = 1'b0;
                    wait_valid(1, 50, n);
                    chk("t3_ts1", ts1_a[1], 8'h5A);
                    chk("t3_ts2", ts2_a[1], 8'hA5);
                    cnt = 0;
                    repeat (40) begin
                        @(negedge clk);
                        if (!cs_n_a[1]) cnt++;
                    end
                    chk("t3_no_cs", cnt, 0);
                    en[1] = 1'b1;
                    wait_cs_low(1, 50);
                    wait_rises(1, 2, 50);
                    rst[1] = 1'b1;
                    @(negedge clk);
                    chk("t4_reset", outs(1), 20'h80000);
                    rst[1] = 1'b0; en[1] = 1'b0;
                    cnt = 0;
                    repeat (30) begin
                        @(negedge clk);
                        if (valid_a[1]) cnt++;
                    end
                    chk("t4_no_valid", cnt, 0);
                    k = 0;
                    c = 0;
                    while (k < 12 && c < 3000) begin
                        en[1]  = $urandom_range(0, 7) != 0;
                        rst[1] = $urandom_range(0, 299) == 0;
                        @(negedge clk);
                        c++;
                        if (valid_a[1]) begin
                            k++;
                            v1[1] = rnd_val(); v2[1] = rnd_val();
                        end
                    end
                    rst[1] = 1'b0;
                    if (k < 12) timeout_fail("random_valids1", 3000);
                end
                begin : s2
                    int n;
                    logic [7:0] e;
                    @(negedge clk);
                    chk("reset2", outs(2), 20'h80000);
                    @(negedge clk);
                    rst[2] = 1'b0; en[2] = 1'b1; v1[2] = 8'h10; v2[2] = 8'h10;
                    wait_valid(2, 100, n);
                    chk("t6_first", n, 73);
                    chk("t6_ts1_first", ts1_a[2], 8'h10);
                    for (int k = 1; k <= 4; k++) begin
                        e = (k % 2 == 1) ? 8'h20 : 8'h10;
                        v1[2] = e; v2[2] = e;
                        wait_valid(2, 100, n);
                        chk("t6_spacing", n, 74);
                        chk("t6_ts1", ts1_a[2], e);
                        chk("t6_ts2", ts2_a[2], e);
                    end
                end
            join
            begin
                #300000;
                timeout_fail("global_timeout", 30000);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
